data_memory_stage: RTL

//  Memory-stage (M) data port of the pipelined MIPS core. Owns the Harvard data RAM.

---
 rtl/data_memory_stage.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/data_memory_stage.sv
// -----------------------------------------------------------------------------
// data_memory_stage
//
// Memory-stage data port of the pipelined MIPS core. Owns the Harvard data RAM
// and services loads/stores from EX/MEM using the ALUOutM byte address.
// WAIT_CYCLES models a slow memory: each access holds StallM high for exactly
// WAIT_CYCLES cycles, followed by one completion cycle. With WAIT_CYCLES=0 the
// RAM behaves as a plain single-cycle memory and the FSM never leaves IDLE.
//
// Handshake: a request is "valid" when (MemReadM | MemWriteM) is high while the
// FSM is IDLE. While StallM is high the pipeline is frozen and the port ignores
// its inputs; the request is finished in the cycle where StallM is low and the
// FSM is in WAIT (the completion cycle). ReadDataM is non-zero only in a read
// completion cycle. Misaligned or out-of-range requests are dropped and flagged
// on AddrErrM for that single cycle.
//
// Ports
//   CLK          in   1           clock, rising edge
//   RST          in   1           asynchronous active-low reset
//   MemReadM     in   1           load in M stage
//   MemWriteM    in   1           store in M stage (wins when both are set)
//   ALUOutM      in   ADDR_WIDTH  byte address
//   WriteDataM   in   DATA_WIDTH  store data
//   ReadDataM    out  DATA_WIDTH  load data, valid in the completion cycle
//   StallM       out  1           freeze request to the hazard unit
//   AddrErrM     out  1           misaligned / out-of-range access flag
//   dbg_state_o  out  1           FSM state for observation (0=IDLE, 1=WAIT)
// -----------------------------------------------------------------------------
module data_memory_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [ADDR_WIDTH-1:0] ALUOutM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  AddrErrM,
    output logic                  dbg_state_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    // The accept edge itself counts as the first stall cycle, so the counter
    // starts one below WAIT_CYCLES.
    localparam logic [CNT_WIDTH-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_WIDTH'(WAIT_CYCLES - 1) : '0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]       addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   wr_q;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic [ADDR_WIDTH-1:0]  word_addr;
    logic [IDX_W-1:0]       idx;
    logic                   req;
    logic                   bad_addr;
    logic                   req_err;
    logic                   req_ok;
    logic                   complete;

    logic                   ram_we;
    logic [IDX_W-1:0]       ram_waddr;
    logic [DATA_WIDTH-1:0]  ram_wdata;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    assign word_addr = ALUOutM >> 2;
    assign idx       = ALUOutM[IDX_W+1:2];
    assign bad_addr  = (ALUOutM[1:0] != 2'b00) || (word_addr >= ADDR_WIDTH'(DEPTH));
    // Gating with RST keeps a request presented during reset from touching
    // anything, including the RAM (which has no reset of its own).
    assign req       = RST && (MemReadM || MemWriteM) && (state_q == S_IDLE);
    assign req_err   = req && bad_addr;
    assign req_ok    = req && !bad_addr;
    assign complete  = (state_q == S_WAIT) && (cnt_q == '0);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (HAS_WAIT && req_ok) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        StallM    = 1'b0;
        AddrErrM  = 1'b0;
        ReadDataM = '0;
        if (RST) begin
            AddrErrM = req_err;
            case (state_q)
                S_IDLE: begin
                    StallM = HAS_WAIT && req_ok;
                    // Zero-wait memory: loads return in the request cycle.
                    if (!HAS_WAIT && req_ok && !MemWriteM) begin
                        ReadDataM = mem[idx];
                    end
                end
                S_WAIT: begin
                    StallM = (cnt_q != '0);
                    if (complete && !wr_q) begin
                        ReadDataM = mem[addr_q];
                    end
                end
                default: begin
                    StallM = 1'b0;
                end
            endcase
        end
    end

    assign dbg_state_o = (state_q == S_WAIT);

    // -------------------------------------------------------------------------
    // Latched request: captured at the accept edge so that inputs changing
    // while the pipeline is frozen cannot disturb the access in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else if (HAS_WAIT && req_ok) begin
            addr_q <= idx;
            data_q <= WriteDataM;
            wr_q   <= MemWriteM;
        end
    end

    // -------------------------------------------------------------------------
    // RAM write port. Writes land at the closing edge of the completion cycle
    // (or of the request cycle with zero wait). An asynchronous reset during
    // WAIT forces the state to IDLE, so the pending write never reaches here.
    // -------------------------------------------------------------------------
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (RST) begin
            if (complete && wr_q) begin
                ram_we    = 1'b1;
                ram_waddr = addr_q;
                ram_wdata = data_q;
            end else if (!HAS_WAIT && req_ok && MemWriteM) begin
                ram_we    = 1'b1;
                ram_waddr = idx;
                ram_wdata = WriteDataM;
            end
        end
    end

    // Contents survive reset by design.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

endmodule
